// File: rtl/fft_reorder.sv
// fft_reorder: bit-reversal reorder buffer at the tail of the SDF FFT pipeline.
// Frames arrive in bit-reversed order and are written into one half of a ping-pong
// RAM. Each completed half is replayed in natural order while the other half fills.
// Optional build macro: FFT_REORDER_ERR_EN adds framing checks and drives frame_err.
module fft_reorder #(
    parameter int unsigned LOG2N  = 7,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic              in_start,
    input  logic              in_end,
    input  logic [DATA_W-1:0] in_real,
    input  logic [DATA_W-1:0] in_img,
    output logic              out_valid,
    output logic              out_start,
    output logic              out_end,
    output logic [DATA_W-1:0] out_real,
    output logic [DATA_W-1:0] out_img,
    output logic              frame_err
);

    localparam int unsigned      N    = 1 << LOG2N;
    localparam logic [LOG2N-1:0] Last = '1;

`ifdef FFT_REORDER_ERR_EN
    localparam bit ErrEn = 1'b1;
`else
    localparam bit ErrEn = 1'b0;
`endif

    typedef enum logic {WrIdle, WrFill} wr_state_e;
    typedef enum logic {RdIdle, RdDrain} rd_state_e;

    // Reverse the LOG2N address bits.
    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] k);
        logic [LOG2N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(LOG2N); i++) begin
            r[i] = k[int'(LOG2N) - 1 - i];
        end
        return r;
    endfunction

    // Write side
    wr_state_e        wr_state_q, wr_state_d;
    logic [LOG2N-1:0] wcnt_q, wcnt_d;
    logic             wbank_q, wbank_d;
    logic             we;
    logic [LOG2N-1:0] waddr;
    logic             launch;
    logic             err_d;

    // Read side
    rd_state_e        rd_state_q, rd_state_d;
    logic [LOG2N-1:0] rcnt_q, rcnt_d;
    logic             re;

    // Storage and read pipeline
    logic [2*DATA_W-1:0] mem [2*N];
    logic [2*DATA_W-1:0] rdata_q;
    logic                rd_valid_q, rd_start_q, rd_end_q;

    // Write FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_state_q <= WrIdle;
            wcnt_q     <= '0;
            wbank_q    <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wcnt_q     <= wcnt_d;
            wbank_q    <= wbank_d;
        end
    end

    // Write FSM next state: capture samples at bit-reversed addresses, flag completion.
    always_comb begin
        wr_state_d = wr_state_q;
        wcnt_d     = wcnt_q;
        wbank_d    = wbank_q;
        we         = 1'b0;
        waddr      = '0;
        launch     = 1'b0;
        err_d      = 1'b0;
        unique case (wr_state_q)
            WrIdle: begin
                if (in_valid && in_start) begin
                    if (ErrEn && in_end) begin
                        // A one-sample frame cannot be legal for N > 1.
                        err_d = 1'b1;
                    end else begin
                        we         = 1'b1;
                        waddr      = '0;
                        wcnt_d     = LOG2N'(1);
                        wr_state_d = WrFill;
                    end
                end
            end
            WrFill: begin
                if (in_valid) begin
                    if (ErrEn && in_start) begin
                        // Drop the partial frame and restart with this sample as index 0.
                        err_d  = 1'b1;
                        we     = 1'b1;
                        waddr  = '0;
                        wcnt_d = LOG2N'(1);
                    end else if (ErrEn && in_end && (wcnt_q != Last)) begin
                        err_d      = 1'b1;
                        wcnt_d     = '0;
                        wr_state_d = WrIdle;
                    end else begin
                        we    = 1'b1;
                        waddr = bitrev(wcnt_q);
                        if (wcnt_q == Last) begin
                            // Missing end strobe is reported but the frame is kept.
                            err_d      = ErrEn && !in_end;
                            wbank_d    = ~wbank_q;
                            launch     = 1'b1;
                            wcnt_d     = '0;
                            wr_state_d = WrIdle;
                        end else begin
                            wcnt_d = wcnt_q + LOG2N'(1);
                        end
                    end
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Read FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_state_q <= RdIdle;
            rcnt_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rcnt_q     <= rcnt_d;
        end
    end

    // Read FSM next state: sweep the read bank in natural order, chain launches without a gap.
    always_comb begin
        rd_state_d = rd_state_q;
        rcnt_d     = rcnt_q;
        re         = 1'b0;
        unique case (rd_state_q)
            RdIdle: begin
                if (launch) begin
                    rd_state_d = RdDrain;
                    rcnt_d     = '0;
                end
            end
            RdDrain: begin
                re = 1'b1;
                if (rcnt_q == Last) begin
                    rcnt_d = '0;
                    if (!launch) begin
                        rd_state_d = RdIdle;
                    end
                end else begin
                    rcnt_d = rcnt_q + LOG2N'(1);
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    // Ping-pong RAM: write into wbank, registered read from the opposite bank. Not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wbank_q, waddr}] <= {in_real, in_img};
        end
        if (re) begin
            rdata_q <= mem[{~wbank_q, rcnt_q}];
        end
    end

    // Strobes travelling alongside the RAM read.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid_q <= 1'b0;
            rd_start_q <= 1'b0;
            rd_end_q   <= 1'b0;
        end else begin
            rd_valid_q <= re;
            rd_start_q <= re && (rcnt_q == '0);
            rd_end_q   <= re && (rcnt_q == Last);
        end
    end

    // Output register stage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_end   <= 1'b0;
            out_real  <= '0;
            out_img   <= '0;
        end else begin
            out_valid <= rd_valid_q;
            out_start <= rd_start_q;
            out_end   <= rd_end_q;
            if (rd_valid_q) begin
                out_real <= rdata_q[2*DATA_W-1:DATA_W];
                out_img  <= rdata_q[DATA_W-1:0];
            end
        end
    end

`ifdef FFT_REORDER_ERR_EN
    logic err_q;

    // Framing error pulse.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign frame_err = err_q;
`else
    logic unused_err;
    assign unused_err = err_d;
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_fft_reorder.sv
// tb_fft_reorder: scoreboard bench for fft_reorder. The driver pushes the expected
// natural-order burst (value, strobes, arrival cycle) per accepted frame; a monitor
// pops and compares every cycle the DUT shows out_valid.
module tb_fft_reorder;

    localparam int LOG2N  = 7;
    localparam int N      = 128;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_start = 1'b0;
    logic              in_end = 1'b0;
    logic [DATA_W-1:0] in_real = '0;
    logic [DATA_W-1:0] in_img = '0;
    logic              out_valid;
    logic              out_start;
    logic              out_end;
    logic [DATA_W-1:0] out_real;
    logic [DATA_W-1:0] out_img;
    logic              frame_err;

    fft_reorder #(.LOG2N(LOG2N), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_start  (in_start),
        .in_end    (in_end),
        .in_real   (in_real),
        .in_img    (in_img),
        .out_valid (out_valid),
        .out_start (out_start),
        .out_end   (out_end),
        .out_real  (out_real),
        .out_img   (out_img),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
        logic              st;
        logic              en;
        int                cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   err_cnt = 0;

    // Count rising edges; read on falling edges only.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [LOG2N-1:0] brev(input int k);
        logic [LOG2N-1:0] kk;
        logic [LOG2N-1:0] r;
        kk = k[LOG2N-1:0];
        for (int i = 0; i < LOG2N; i++) r[i] = kk[LOG2N-1-i];
        return r;
    endfunction

    function automatic logic [DATA_W-1:0] val(input int f, input int idx);
        return DATA_W'((f << 16) | idx);
    endfunction

    // Monitor: compare every presented output against the scoreboard head.
    always @(negedge clk) begin
        if (rstn) begin
            if (frame_err) err_cnt++;
            if (out_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output: got re=%0h st=%0b en=%0b at cycle %0d, required no output",
                             out_real, out_start, out_end, cyc);
                end else begin
                    e = sb.pop_front();
                    if (out_real !== e.re || out_img !== e.im || out_start !== e.st ||
                        out_end !== e.en || cyc != e.cyc) begin
                        n_fail++;
                        $display("FAIL bin: got re=%0h im=%0h st=%0b en=%0b cyc=%0d, required re=%0h im=%0h st=%0b en=%0b cyc=%0d",
                                 out_real, out_img, out_start, out_end, cyc,
                                 e.re, e.im, e.st, e.en, e.cyc);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missing_output: got out_valid=0 at cycle %0d, required re=%0h",
                         cyc, sb[0].re);
                e = sb.pop_front();
            end
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
        in_start = 1'b0;
        in_end   = 1'b0;
    endtask

    // Drive `count` samples of frame f (value = frame tag | bitrev(k)); end strobe at
    // index end_at (-1 for none); optionally push the expected natural-order burst.
    task automatic send(input int f, input int count, input bit gap, input int end_at,
                        input bit expect_out, output int last_acc);
        int   k = 0;
        int   slot = 0;
        exp_t x;
        last_acc = 0;
        while (k < count) begin
            @(negedge clk);
            if (gap && (slot % 3 == 2)) begin
                in_valid = 1'b0;
                in_start = 1'b0;
                in_end   = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_start = (k == 0);
                in_end   = (k == end_at);
                in_real  = val(f, int'(brev(k)));
                in_img   = ~val(f, int'(brev(k)));
                last_acc = cyc + 1;
                k++;
            end
            slot++;
        end
        if (expect_out) begin
            for (int b = 0; b < N; b++) begin
                x.re  = val(f, b);
                x.im  = ~val(f, b);
                x.st  = (b == 0);
                x.en  = (b == N - 1);
                x.cyc = last_acc + 2 + b;
                sb.push_back(x);
            end
        end
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(sb.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    int acc;
    int err_base;
    int t;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_strobes", 64'({out_start, out_end}), 64'd0);
        check("rst_data", {out_real, out_img}, 64'd0);
        check("rst_frame_err", 64'(frame_err), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_out_valid", 64'(out_valid), 64'd0);

        // Stray samples without a start strobe are discarded, then a single frame.
        @(negedge clk);
        in_valid = 1'b1; in_start = 1'b0; in_real = 32'hdead; in_img = 32'hbeef;
        @(negedge clk);
        in_valid = 1'b0;
        send(1, N, 1'b0, N - 1, 1'b1, acc);
        idle();
        wait_drain("single_drain");

        // Three back-to-back frames: contiguous 384-cycle burst.
        send(2, N, 1'b0, N - 1, 1'b1, acc);
        send(3, N, 1'b0, N - 1, 1'b1, acc);
        send(4, N, 1'b0, N - 1, 1'b1, acc);
        idle();
        wait_drain("b2b_drain");

        // Gapped input.
        send(5, N, 1'b1, N - 1, 1'b1, acc);
        idle();
        wait_drain("gapped_drain");

`ifdef FFT_REORDER_ERR_EN
        // Restart via in_start at wcnt=50.
        err_base = err_cnt;
        send(9, 50, 1'b0, -1, 1'b0, acc);
        send(6, N, 1'b0, N - 1, 1'b1, acc);
        idle();
        wait_drain("restart_drain");
        check("restart_err_pulses", 64'(err_cnt - err_base), 64'd1);

        // Early in_end at wcnt=100: abort, no burst.
        err_base = err_cnt;
        send(10, 101, 1'b0, 100, 1'b0, acc);
        idle();
        repeat (N + 8) @(negedge clk);
        check("early_end_err_pulses", 64'(err_cnt - err_base), 64'd1);
        check("early_end_no_output", 64'(sb.size()), 64'd0);
`endif

        // Frame without an end strobe still completes.
        err_base = err_cnt;
        send(7, N, 1'b0, -1, 1'b1, acc);
        idle();
        wait_drain("no_end_drain");
`ifdef FFT_REORDER_ERR_EN
        check("no_end_err_pulses", 64'(err_cnt - err_base), 64'd1);
`else
        check("no_end_err_pulses", 64'(err_cnt - err_base), 64'd0);
`endif

        // Reset while bin 40 is on the output.
        send(11, N, 1'b0, N - 1, 1'b1, acc);
        idle();
        t = 0;
        while (cyc != acc + 41 && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("reach_bin40", 64'(cyc), 64'(acc + 41));
        @(posedge clk);
        #1;
        check("pre_rst_bin40", 64'(out_real), 64'(val(11, 40)));
        rstn = 1'b0;
        #1;
        check("midrst_valid", 64'({out_valid, out_start, out_end}), 64'd0);
        check("midrst_data", {out_real, out_img}, 64'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        repeat (N + 8) @(negedge clk);
        check("no_partial_burst", 64'(sb.size()), 64'd0);
        send(8, N, 1'b0, N - 1, 1'b1, acc);
        idle();
        wait_drain("fresh_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_reorder.md
# fft_reorder

Bit-reversal reorder buffer at the tail of the 128-point SDF FFT pipeline, directly after the last butterfly/rotator stage. It captures each frame of bit-reversed complex samples, delimited by start/end strobes, into one half of a ping-pong RAM. It then replays the frame in natural frequency order from the other half. Back-to-back frames stream with no stall.

## Interface
Parameters:
- `LOG2N`, 7: log2 of FFT length. N = 1<<LOG2N.
- `DATA_W`, 32: width of each real/imag component. Two's complement, passed through unchanged.

Ports:
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rstn`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, 1: input sample valid this cycle.
- `in_start`, in, 1: qualifies the first sample (index 0) of a frame; honoured only with `in_valid`.
- `in_end`, in, 1: qualifies the last sample (index N-1) of a frame; honoured only with `in_valid`.
- `in_real` / `in_img`, in, DATA_W: sample in bit-reversed order.
- `out_valid`, out, 1: output sample valid.
- `out_start`, out, 1: first natural-order sample, bin 0.
- `out_end`, out, 1: last natural-order sample, bin N-1.
- `out_real` / `out_img`, out, DATA_W: sample in natural order.
- `frame_err`, out, 1: one-cycle pulse on a framing violation.

## Operation
- Storage: 2 banks × N words × 2·DATA_W. Write bank select is `wbank`; read bank is the opposite bank.
- Write FSM, states IDLE and FILL:
  - In IDLE, a cycle with `in_valid & in_start` writes address bitrev(0)=0, sets `wcnt`=1 and enters FILL. Other valid samples are discarded.
  - In FILL, each valid sample writes address bitrev(`wcnt`) in `wbank`, then `wcnt` increments. Cycles without `in_valid` hold state.
  - When the sample at `wcnt`=N-1 is written, the frame completes: `wbank` toggles, a read launch is requested, and the FSM returns to IDLE.
  - The completing cycle may also carry `in_start` for the next frame only if N=1; this is not a supported case.
- bitrev(k) reverses the LOG2N bits of k. Example for N=128: bitrev(1)=64, bitrev(3)=96.
- Read FSM, states IDLE and DRAIN:
  - A launch request moves it to DRAIN with `rcnt`=0. Each cycle it reads address `rcnt` from the read bank and increments `rcnt`.
  - After `rcnt`=N-1 it returns to IDLE.
  - A launch arriving in the same cycle as the last DRAIN read starts the next DRAIN immediately, with no gap.
- Framing checks, when `FFT_REORDER_ERR_EN` is defined:
  - `in_start` in FILL: pulse `frame_err`, discard the partial frame, restart with this sample at index 0. `wbank` does not toggle.
  - `in_end` with `wcnt`≠N-1: pulse `frame_err`, discard the partial frame, go to IDLE.
  - Completion at `wcnt`=N-1 without `in_end`: pulse `frame_err`, but the frame is still accepted.
- Overrun cannot occur: a bank needs ≥N cycles to fill and exactly N cycles to drain.

## Timing
- RAM read is registered, so there is 1 cycle from read address to data. Output registers follow the RAM output.
- Latency: the first output (`out_start`, bin 0) appears 2 cycles after the cycle in which the last input sample (index N-1) is accepted.
- Output burst is exactly N consecutive `out_valid` cycles. `out_start` is on the first of them and `out_end` on the last.
- With contiguous input frames, output is also contiguous: `out_valid` stays high continuously.
- Reset values: `out_valid`, `out_start`, `out_end` and `frame_err` are 0. `out_real` and `out_img` are 0. Both FSMs are IDLE, `wbank`=0, and all counters are 0.
- RAM contents are not reset.
- Reset asserted mid-frame aborts the fill and any drain in progress. No partial burst is emitted after release.

## Configuration
- `FFT_REORDER_ERR_EN` defined: the framing checks above are built in and `frame_err` is driven.
- Undefined: `frame_err` is tied to 0, `in_end` is ignored, and frames complete purely on `wcnt` reaching N-1.

## Test plan
- Single frame: drive input value = bitrev(k) for k=0..127 with start/end strobes. Expect out_real = 0..127 in order, `out_start` at bin 0, `out_end` at bin 127, first output 2 cycles after the last input.
- Back-to-back: 3 contiguous frames → 384 contiguous `out_valid` cycles; every bin matches, with no gap and no bank corruption.
- Gapped input: `in_valid` deasserted on every third cycle within a frame → output is still exactly 128 contiguous natural-order samples.
- With `FFT_REORDER_ERR_EN`: `in_start` at `wcnt`=50 → one `frame_err` pulse. The next 128 samples form a valid frame and output is correct; no output appears for the aborted frame.
- With `FFT_REORDER_ERR_EN`: `in_end` at `wcnt`=100 → `frame_err` pulse and no output burst.
- Reset mid-drain: `rstn` low at output bin 40 → all outputs are 0 immediately. After release, a fresh frame reorders correctly.
